// File: rtl/port_ingress_framer_if.sv
// Host-side valid/ready stream plus hydra write-lane signals for one ingress port.
// The master modport is the host/hydra side; the slave modport is the framer.
`timescale 1ns/1ps
interface port_ingress_framer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic [3:0]  in_dest;
  logic [2:0]  in_prio;
  logic        pause;
  logic        wr_sop;
  logic        wr_eop;
  logic        wr_vld;
  logic [15:0] wr_data;
  logic        drop;

  modport master (
    output in_valid, in_data, in_last, in_dest, in_prio, pause,
    input  in_ready, wr_sop, wr_eop, wr_vld, wr_data, drop
  );

  modport slave (
    input  in_valid, in_data, in_last, in_dest, in_prio, pause,
    output in_ready, wr_sop, wr_eop, wr_vld, wr_data, drop
  );
endinterface

// File: rtl/port_ingress_framer.sv
// Store-and-forward ingress framer: buffers one packet, then emits sop/header/payload/eop.
// Define INGRESS_STATS_EN to add saturating pkt_cnt/drop_cnt outputs.
`timescale 1ns/1ps
module port_ingress_framer #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  port_ingress_framer_if.slave   bus
`ifdef INGRESS_STATS_EN
  ,
  output logic [15:0]            pkt_cnt,
  output logic [15:0]            drop_cnt
`endif
);

  typedef enum logic [2:0] {FILL, DROP, ARB, SOP, HDR, DATA, EOP} state_e;

  localparam logic [AW:0] MAX_CNT = (AW+1)'(DEPTH);

  state_e      state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]  dest_q, dest_d;
  logic [2:0]  prio_q, prio_d;
  logic        in_ready_q, in_ready_d;
  logic        wr_sop_q, wr_sop_d;
  logic        wr_eop_q, wr_eop_d;
  logic        wr_vld_q, wr_vld_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        drop_q, drop_d;
  logic        accept;
  logic        mem_we;
  logic [15:0] mem [DEPTH];

  assign accept = bus.in_valid & in_ready_q;

  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_ptr_d  = rd_ptr_q;
    dest_d    = dest_q;
    prio_d    = prio_q;
    drop_d    = 1'b0;
    mem_we    = 1'b0;
    wr_data_d = 16'h0000;

    case (state_q)
      FILL: if (accept) begin
        if (cnt_q == MAX_CNT) begin
          // Buffer already full: an extra last word drops immediately, otherwise discard the rest.
          if (bus.in_last) begin
            drop_d = 1'b1;
            cnt_d  = '0;
          end else begin
            state_d = DROP;
          end
        end else begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == '0) begin
            dest_d = bus.in_dest;
            prio_d = bus.in_prio;
          end
          if (bus.in_last) state_d = ARB;
        end
      end
      DROP: if (accept && bus.in_last) begin
        drop_d   = 1'b1;
        cnt_d    = '0;
        rd_ptr_d = '0;
        state_d  = FILL;
      end
      ARB: if (!bus.pause) state_d = SOP;
      SOP: begin
        state_d   = HDR;
        wr_data_d = {9'(cnt_q - 1'b1), prio_q, dest_q};
      end
      HDR: begin
        state_d   = DATA;
        wr_data_d = mem[rd_ptr_q[AW-1:0]];
        rd_ptr_d  = rd_ptr_q + 1'b1;
      end
      DATA: if (rd_ptr_q == cnt_q) begin
        state_d = EOP;
      end else begin
        wr_data_d = mem[rd_ptr_q[AW-1:0]];
        rd_ptr_d  = rd_ptr_q + 1'b1;
      end
      EOP: begin
        state_d  = FILL;
        cnt_d    = '0;
        rd_ptr_d = '0;
      end
      default: state_d = FILL;
    endcase

    // Outputs are decoded from the next state and registered, so pause never reaches wr_* combinationally.
    in_ready_d = (state_d == FILL) || (state_d == DROP);
    wr_sop_d   = (state_d == SOP);
    wr_eop_d   = (state_d == EOP);
    wr_vld_d   = (state_d == HDR) || (state_d == DATA);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      dest_q     <= '0;
      prio_q     <= '0;
      in_ready_q <= 1'b1;
      wr_sop_q   <= 1'b0;
      wr_eop_q   <= 1'b0;
      wr_vld_q   <= 1'b0;
      wr_data_q  <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      dest_q     <= dest_d;
      prio_q     <= prio_d;
      in_ready_q <= in_ready_d;
      wr_sop_q   <= wr_sop_d;
      wr_eop_q   <= wr_eop_d;
      wr_vld_q   <= wr_vld_d;
      wr_data_q  <= wr_data_d;
      drop_q     <= drop_d;
    end
  end

  // NOTE: the buffer is not reset; cnt/rd_ptr gate every read, so stale contents are never emitted.
  always_ff @(posedge clk) begin
    if (mem_we) mem[cnt_q[AW-1:0]] <= bus.in_data;
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_sop   = wr_sop_q;
  assign bus.wr_eop   = wr_eop_q;
  assign bus.wr_vld   = wr_vld_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.drop     = drop_q;

`ifdef INGRESS_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (wr_eop_d && pkt_cnt_q != 16'hFFFF)  pkt_cnt_d  = pkt_cnt_q + 16'd1;
    if (drop_d && drop_cnt_q != 16'hFFFF)   drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_port_ingress_framer.sv
// Directed self-checking bench for port_ingress_framer (stats checks when INGRESS_STATS_EN is defined).
`timescale 1ns/1ps
module tb_port_ingress_framer;
  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  port_ingress_framer_if bus();

`ifdef INGRESS_STATS_EN
  logic [15:0] pkt_cnt, drop_cnt;
`endif

  port_ingress_framer #(.DEPTH(DEPTH), .AW(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef INGRESS_STATS_EN
    ,
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int sop_seen = 0;
  int drop_seen = 0;

  always @(posedge clk) begin
    if (bus.wr_sop) sop_seen++;
    if (bus.drop)   drop_seen++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Words carry seed+i; dest/prio are corrupted after the first word to prove they latch once.
  task automatic send_pkt(input int n, input logic [3:0] dest, input logic [2:0] prio,
                          input logic [15:0] seed);
    check("in_ready_before_pkt", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = seed + 16'(i);
      bus.in_last  = (i == n - 1);
      bus.in_dest  = (i == 0) ? dest : ~dest;
      bus.in_prio  = (i == 0) ? prio : ~prio;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Called on the first negedge with the framer in ARB and pause low at the coming edge.
  task automatic expect_pkt(input string name, input int n, input logic [15:0] hdr,
                            input logic [15:0] seed, input int pause_at);
    check($sformatf("%s_arb_sop", name), 32'(bus.wr_sop), 32'd0);
    check($sformatf("%s_arb_ready", name), 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check($sformatf("%s_sop", name), 32'(bus.wr_sop), 32'd1);
    check($sformatf("%s_sop_vld", name), 32'(bus.wr_vld), 32'd0);
    @(negedge clk);
    check($sformatf("%s_hdr_vld", name), 32'(bus.wr_vld), 32'd1);
    check($sformatf("%s_hdr", name), 32'(bus.wr_data), 32'(hdr));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == pause_at) bus.pause = 1'b1;
      check($sformatf("%s_data%0d_vld", name, i), 32'(bus.wr_vld), 32'd1);
      check($sformatf("%s_data%0d", name, i), 32'(bus.wr_data), 32'(seed + 16'(i)));
    end
    @(negedge clk);
    check($sformatf("%s_eop", name), 32'(bus.wr_eop), 32'd1);
    check($sformatf("%s_eop_vld", name), 32'(bus.wr_vld), 32'd0);
    check($sformatf("%s_eop_data", name), 32'(bus.wr_data), 32'd0);
    bus.pause = 1'b0;
    @(negedge clk);
    check($sformatf("%s_post_eop", name), 32'(bus.wr_eop), 32'd0);
    check($sformatf("%s_post_ready", name), 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s0, d0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.in_dest  = '0;
    bus.in_prio  = '0;
    bus.pause    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_sop",   32'(bus.wr_sop),   32'd0);
    check("rst_eop",   32'(bus.wr_eop),   32'd0);
    check("rst_vld",   32'(bus.wr_vld),   32'd0);
    check("rst_data",  32'(bus.wr_data),  32'd0);
    check("rst_drop",  32'(bus.drop),     32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1) 32-word packet, dest=3 prio=4
    send_pkt(32, 4'd3, 3'd4, 16'h1000);
    expect_pkt("t1", 32, 16'h0FC3, 16'h1000, -1);

    // 2) single-word packet
    send_pkt(1, 4'd15, 3'd7, 16'hBEEF);
    expect_pkt("t2", 1, 16'h007F, 16'hBEEF, -1);

    // 3) pause held after last word, then raised during DATA
    bus.pause = 1'b1;
    send_pkt(5, 4'd2, 3'd1, 16'h3000);
    for (int i = 0; i < 10; i++) begin
      check("t3_paused_sop", 32'(bus.wr_sop), 32'd0);
      check("t3_paused_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.pause = 1'b0;
    expect_pkt("t3", 5, 16'h0212, 16'h3000, 1);

    // 4) DEPTH+1 words: drop on the last word, no sop
    s0 = sop_seen;
    d0 = drop_seen;
    send_pkt(DEPTH + 1, 4'd5, 3'd2, 16'h4000);
    check("t4_drop_pulse", 32'(bus.drop), 32'd1);
    check("t4_drop_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("t4_drop_clear", 32'(bus.drop), 32'd0);
    check("t4_no_sop", 32'(sop_seen - s0), 32'd0);
    check("t4_one_drop", 32'(drop_seen - d0), 32'd1);
    send_pkt(4, 4'd9, 3'd6, 16'h5000);
    expect_pkt("t4", 4, 16'h01E9, 16'h5000, -1);

    // 4b) DEPTH+3 words: passes through the discard state, still a single drop
    s0 = sop_seen;
    d0 = drop_seen;
    send_pkt(DEPTH + 3, 4'd1, 3'd1, 16'h7000);
    check("t4b_drop_pulse", 32'(bus.drop), 32'd1);
    @(negedge clk);
    check("t4b_no_sop", 32'(sop_seen - s0), 32'd0);
    check("t4b_one_drop", 32'(drop_seen - d0), 32'd1);

    // 4c) exactly DEPTH words: forwarded, len field = DEPTH-1
    send_pkt(DEPTH, 4'd0, 3'd0, 16'h8000);
    expect_pkt("t4c", DEPTH, 16'hFF80, 16'h8000, -1);

    // 5) reset in the middle of DATA
    send_pkt(8, 4'd1, 3'd3, 16'h6000);
    repeat (4) @(negedge clk);
    check("t5_in_data", 32'(bus.wr_vld), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_vld",   32'(bus.wr_vld),   32'd0);
    check("t5_rst_eop",   32'(bus.wr_eop),   32'd0);
    check("t5_rst_ready", 32'(bus.in_ready), 32'd1);
    check("t5_rst_data",  32'(bus.wr_data),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    send_pkt(2, 4'd10, 3'd5, 16'hA5A0);
    expect_pkt("t5", 2, 16'h00DA, 16'hA5A0, -1);

`ifdef INGRESS_STATS_EN
    // 6) 3 good packets + 1 oversize
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_pkt_cnt_rst",  32'(pkt_cnt),  32'd0);
    check("t6_drop_cnt_rst", 32'(drop_cnt), 32'd0);
    for (int p = 0; p < 3; p++) begin
      send_pkt(3, 4'd4, 3'd2, 16'h0100);
      expect_pkt("t6", 3, 16'h0124, 16'h0100, -1);
    end
    send_pkt(DEPTH + 1, 4'd4, 3'd2, 16'h0200);
    @(negedge clk);
    check("t6_pkt_cnt",  32'(pkt_cnt),  32'd3);
    check("t6_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
